// File: rtl/frame_slot_sched_if.sv
// Frame slot scheduler bus: writer/reader completion strobes and freeze request
// toward the scheduler; slot base addresses, reader-valid flag and drop/repeat
// statistics back from it.
interface frame_slot_sched_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  wr_done_stb_i;
    logic                  rd_done_stb_i;
    logic                  freeze_i;
    logic [ADDR_WIDTH-1:0] wr_frame_addr_o;
    logic [ADDR_WIDTH-1:0] rd_frame_addr_o;
    logic                  rd_frame_valid_o;
    logic                  drop_stb_o;
    logic                  repeat_stb_o;
    logic [CNT_WIDTH-1:0]  drop_cnt_o;
    logic [CNT_WIDTH-1:0]  repeat_cnt_o;

    // Side that produces the strobes (writer/reader engines, or a bench).
    modport master (
        output wr_done_stb_i, rd_done_stb_i, freeze_i,
        input  wr_frame_addr_o, rd_frame_addr_o, rd_frame_valid_o,
        input  drop_stb_o, repeat_stb_o, drop_cnt_o, repeat_cnt_o
    );

    // Scheduler side.
    modport slave (
        input  wr_done_stb_i, rd_done_stb_i, freeze_i,
        output wr_frame_addr_o, rd_frame_addr_o, rd_frame_valid_o,
        output drop_stb_o, repeat_stb_o, drop_cnt_o, repeat_cnt_o
    );
endinterface

// File: rtl/frame_slot_sched.sv
// Multi-slot frame buffer scheduler. One slot is being written, one is being
// read, and at most one holds the newest completed-but-unread frame. A slower
// reader repeats its slot, a faster writer overwrites (drops) the pending frame.
module frame_slot_sched #(
    parameter int unsigned START_ADDR      = 0,
    parameter int unsigned FRAMES_AMOUNT   = 3,
    parameter int unsigned BYTES_PER_FRAME = 4147200,
    parameter int          ADDR_WIDTH      = 32,
    parameter int          CNT_WIDTH       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    frame_slot_sched_if.slave    bus
);

    // Three distinct slot roles need at least three slots.
    if (FRAMES_AMOUNT < 3) begin : g_bad_frames
        $error("frame_slot_sched: FRAMES_AMOUNT must be at least 3");
    end

    localparam int IDX_W = $clog2(FRAMES_AMOUNT);
    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t LAST_IDX = idx_t'(FRAMES_AMOUNT - 1);

    function automatic idx_t next_idx(input idx_t i);
        return (i == LAST_IDX) ? '0 : i + idx_t'(1);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] slot_addr(input idx_t i);
        return ADDR_WIDTH'(64'(START_ADDR) + 64'(i) * 64'(BYTES_PER_FRAME));
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic              en);
        return (en && (cnt != '1)) ? cnt + CNT_WIDTH'(1) : cnt;
    endfunction

    idx_t                  wr_idx_q, wr_idx_d;
    idx_t                  rd_idx_q, rd_idx_d;
    idx_t                  rdy_idx_q, rdy_idx_d;
    logic                  rdy_valid_q, rdy_valid_d;
    logic                  rd_active_q, rd_active_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  drop_stb_q, drop_stb_d;
    logic                  repeat_stb_q, repeat_stb_d;
    logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
    logic [CNT_WIDTH-1:0]  repeat_cnt_q, repeat_cnt_d;

    // Intermediate view after the writer update, before the reader update.
    idx_t                  rdy_idx_w;
    logic                  rdy_valid_w;
    logic                  advance;
    logic                  take;
    idx_t                  wr_cand;

    // Next-state: writer completion first, then reader advance, then writer slot pick.
    always_comb begin
        rdy_idx_w    = bus.wr_done_stb_i ? wr_idx_q : rdy_idx_q;
        rdy_valid_w  = bus.wr_done_stb_i | rdy_valid_q;
        // The reader always grabs the newest frame, so an older pending one is lost.
        drop_stb_d   = bus.wr_done_stb_i & rdy_valid_q;

        advance      = bus.rd_done_stb_i | (~rd_active_q & rdy_valid_w);
        take         = advance & ~bus.freeze_i & rdy_valid_w;

        rd_idx_d     = rd_idx_q;
        rd_active_d  = rd_active_q;
        rdy_idx_d    = rdy_idx_w;
        rdy_valid_d  = rdy_valid_w;
        repeat_stb_d = 1'b0;
        if (take) begin
            rd_idx_d    = rdy_idx_w;
            rd_active_d = 1'b1;
            rdy_valid_d = 1'b0;
        end else if (bus.rd_done_stb_i) begin
            repeat_stb_d = 1'b1;
        end

        // Only one slot (the reader's) can block the successor, so two steps suffice.
        wr_cand  = next_idx(wr_idx_q);
        if (rd_active_d && (wr_cand == rd_idx_d)) begin
            wr_cand = next_idx(wr_cand);
        end
        wr_idx_d = bus.wr_done_stb_i ? wr_cand : wr_idx_q;

        wr_addr_d    = slot_addr(wr_idx_d);
        rd_addr_d    = slot_addr(rd_idx_d);
        drop_cnt_d   = sat_inc(drop_cnt_q, drop_stb_d);
        repeat_cnt_d = sat_inc(repeat_cnt_q, repeat_stb_d);
    end

    // State and registered outputs; reset discards all slot ownership.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            rdy_idx_q    <= '0;
            rdy_valid_q  <= 1'b0;
            rd_active_q  <= 1'b0;
            wr_addr_q    <= slot_addr('0);
            rd_addr_q    <= slot_addr('0);
            drop_stb_q   <= 1'b0;
            repeat_stb_q <= 1'b0;
            drop_cnt_q   <= '0;
            repeat_cnt_q <= '0;
        end else begin
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            rdy_idx_q    <= rdy_idx_d;
            rdy_valid_q  <= rdy_valid_d;
            rd_active_q  <= rd_active_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            drop_stb_q   <= drop_stb_d;
            repeat_stb_q <= repeat_stb_d;
            drop_cnt_q   <= drop_cnt_d;
            repeat_cnt_q <= repeat_cnt_d;
        end
    end

    assign bus.wr_frame_addr_o  = wr_addr_q;
    assign bus.rd_frame_addr_o  = rd_addr_q;
    assign bus.rd_frame_valid_o = rd_active_q;
    assign bus.drop_stb_o       = drop_stb_q;
    assign bus.repeat_stb_o     = repeat_stb_q;
    assign bus.drop_cnt_o       = drop_cnt_q;
    assign bus.repeat_cnt_o     = repeat_cnt_q;

endmodule

// File: tb/tb_frame_slot_sched.sv
// Bench for frame_slot_sched: directed scenarios plus randomized traffic
// against a slot-role reference model, and a second instance with 2-bit
// counters and a non-zero base address for saturation and reset.
module tb_frame_slot_sched;
    localparam int     F      = 3;
    localparam longint BPF    = 4147200;
    localparam longint START  = 0;
    localparam longint START2 = 32'h1000;
    localparam int     CMAX   = 65535;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rst_s;
    int   n_cmp = 0;
    int   n_err = 0;

    frame_slot_sched_if #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) bus ();
    frame_slot_sched_if #(.ADDR_WIDTH(32), .CNT_WIDTH(2))  bus_s ();

    frame_slot_sched #(
        .START_ADDR(32'(START)), .FRAMES_AMOUNT(F), .BYTES_PER_FRAME(32'(BPF)),
        .ADDR_WIDTH(32), .CNT_WIDTH(16)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );

    frame_slot_sched #(
        .START_ADDR(32'(START2)), .FRAMES_AMOUNT(F), .BYTES_PER_FRAME(32'(BPF)),
        .ADDR_WIDTH(32), .CNT_WIDTH(2)
    ) dut_s (
        .clk_i(clk), .rst_i(rst_s), .bus(bus_s)
    );

    // Reference model: slot roles as plain integers.
    int m_wr, m_rd, m_rdy, m_dcnt, m_rcnt;
    bit m_rdyv, m_act, m_drop, m_rep;

    function automatic logic [31:0] addr_of(input longint base, input int idx);
        longint a;
        a = base + longint'(idx) * BPF;
        return a[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit w, input bit d, input bit f);
        int k;
        if (r) begin
            m_wr = 0; m_rd = 0; m_rdy = 0; m_rdyv = 0; m_act = 0;
            m_drop = 0; m_rep = 0; m_dcnt = 0; m_rcnt = 0;
            return;
        end
        m_drop = 0;
        m_rep  = 0;
        if (w) begin
            if (m_rdyv) m_drop = 1;
            m_rdy  = m_wr;
            m_rdyv = 1;
        end
        if ((d || (!m_act && m_rdyv)) && !f && m_rdyv) begin
            m_rd   = m_rdy;
            m_rdyv = 0;
            m_act  = 1;
        end else if (d) begin
            m_rep = 1;
        end
        if (w) begin
            // First slot after the current one that the reader does not hold.
            k = m_wr;
            do k = (k + 1) % F; while (m_act && k == m_rd);
            m_wr = k;
        end
        if (m_drop && m_dcnt < CMAX) m_dcnt++;
        if (m_rep && m_rcnt < CMAX) m_rcnt++;
    endtask

    task automatic check_model();
        chk("wr_addr", bus.wr_frame_addr_o, addr_of(START, m_wr));
        chk("rd_valid", bus.rd_frame_valid_o, m_act);
        if (m_act) chk("rd_addr", bus.rd_frame_addr_o, addr_of(START, m_rd));
        chk("drop_stb", bus.drop_stb_o, m_drop);
        chk("repeat_stb", bus.repeat_stb_o, m_rep);
        chk("drop_cnt", bus.drop_cnt_o, m_dcnt);
        chk("repeat_cnt", bus.repeat_cnt_o, m_rcnt);
    endtask

    // One clock on the main instance; outputs checked 1 ns after the edge.
    task automatic apply(input bit r, input bit w, input bit d, input bit f);
        rst               = r;
        bus.wr_done_stb_i = w;
        bus.rd_done_stb_i = d;
        bus.freeze_i      = f;
        @(posedge clk);
        model_step(r, w, d, f);
        #1;
        check_model();
    endtask

    task automatic apply_s(input bit r, input bit w, input bit d);
        rst_s               = r;
        bus_s.wr_done_stb_i = w;
        bus_s.rd_done_stb_i = d;
        bus_s.freeze_i      = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_s = 1'b1;
        bus_s.wr_done_stb_i = 1'b0;
        bus_s.rd_done_stb_i = 1'b0;
        bus_s.freeze_i      = 1'b0;

        // Reset state
        apply(1, 0, 0, 0);
        apply(1, 1, 1, 0);
        chk("rst_wr_addr", bus.wr_frame_addr_o, 32'd0);
        chk("rst_rd_valid", bus.rd_frame_valid_o, 1'b0);

        // Startup: first frame
        apply(0, 1, 0, 0);
        chk("start_wr_addr", bus.wr_frame_addr_o, 32'd4147200);
        apply(0, 0, 0, 0);
        chk("start_rd_valid", bus.rd_frame_valid_o, 1'b1);
        chk("start_rd_addr", bus.rd_frame_addr_o, 32'd0);

        // Writer faster than reader: 1 -> 2 -> 1, one drop
        apply(0, 1, 0, 0);
        chk("wfast_wr_addr2", bus.wr_frame_addr_o, 32'd8294400);
        chk("wfast_no_drop", bus.drop_stb_o, 1'b0);
        apply(0, 1, 0, 0);
        chk("wfast_wr_addr1", bus.wr_frame_addr_o, 32'd4147200);
        chk("wfast_drop_stb", bus.drop_stb_o, 1'b1);
        chk("wfast_drop_cnt", bus.drop_cnt_o, 16'd1);
        apply(0, 0, 0, 0);
        chk("wfast_drop_clr", bus.drop_stb_o, 1'b0);

        // Reader faster: consume pending slot 2, then repeat it
        apply(0, 0, 1, 0);
        chk("rfast_take", bus.rd_frame_addr_o, 32'd8294400);
        apply(0, 0, 1, 0);
        chk("rfast_rep_stb", bus.repeat_stb_o, 1'b1);
        chk("rfast_rd_addr", bus.rd_frame_addr_o, 32'd8294400);
        chk("rfast_rep_cnt", bus.repeat_cnt_o, 16'd1);

        // Simultaneous completion: reader 0, writer 1, nothing pending
        apply(1, 0, 0, 0);
        apply(0, 1, 0, 0);
        apply(0, 1, 1, 0);
        chk("sim_rd_addr", bus.rd_frame_addr_o, 32'd4147200);
        chk("sim_wr_addr", bus.wr_frame_addr_o, 32'd8294400);
        chk("sim_drop", bus.drop_stb_o, 1'b0);
        chk("sim_repeat", bus.repeat_stb_o, 1'b0);

        // Freeze holds the reader while a frame is pending, release moves it
        apply(0, 1, 0, 0);
        apply(0, 0, 1, 1);
        chk("frz_rep_stb", bus.repeat_stb_o, 1'b1);
        chk("frz_rd_held", bus.rd_frame_addr_o, 32'd4147200);
        apply(0, 0, 1, 0);
        chk("frz_rel_move", bus.rd_frame_addr_o, 32'd8294400);
        chk("frz_rel_norep", bus.repeat_stb_o, 1'b0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            apply($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
        end
        apply(0, 0, 0, 0);

        // Saturation on 2-bit counters, then reset mid-stream
        apply_s(1, 0, 0);
        chk("s_rst_wr_addr", bus_s.wr_frame_addr_o, 32'h1000);
        apply_s(0, 1, 0);
        for (int i = 0; i < 5; i++) apply_s(0, 0, 1);
        chk("s_rep_sat", bus_s.repeat_cnt_o, 2'd3);
        chk("s_rep_stb", bus_s.repeat_stb_o, 1'b1);
        chk("s_rd_valid", bus_s.rd_frame_valid_o, 1'b1);
        apply_s(1, 1, 1);
        chk("s_rst_wr", bus_s.wr_frame_addr_o, 32'h1000);
        chk("s_rst_rd", bus_s.rd_frame_addr_o, 32'h1000);
        chk("s_rst_valid", bus_s.rd_frame_valid_o, 1'b0);
        chk("s_rst_rstb", bus_s.repeat_stb_o, 1'b0);
        chk("s_rst_dstb", bus_s.drop_stb_o, 1'b0);
        chk("s_rst_rcnt", bus_s.repeat_cnt_o, 2'd0);
        chk("s_rst_dcnt", bus_s.drop_cnt_o, 2'd0);
        apply_s(0, 1, 0);
        chk("s_restart_wr", bus_s.wr_frame_addr_o, addr_of(START2, 1));
        chk("s_restart_rd", bus_s.rd_frame_addr_o, addr_of(START2, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/frame_slot_sched.md
FRAME_SLOT_SCHED -- requirements
Module: frame_slot_sched

Interface
REQ-001 SHALL have parameter START_ADDR, default 0, byte address of frame slot 0.
REQ-002 SHALL have parameter FRAMES_AMOUNT, default 3, number of frame slots; values below 3 SHALL be rejected at elaboration.
REQ-003 SHALL have parameter BYTES_PER_FRAME, default 4147200, slot stride in bytes.
REQ-004 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-005 SHALL have parameter CNT_WIDTH, default 16, statistics counter width.
REQ-006 SHALL have ports: clk_i  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have ports: rst_i  input  1  reset; synchronous, active-high.
REQ-008 wr_done_stb_i  input  1  writer finished current slot (1-cycle pulse).
REQ-009 rd_done_stb_i  input  1  reader finished current slot (1-cycle pulse).
REQ-010 freeze_i  input  1  hold reader on current slot (repeat).
REQ-011 wr_frame_addr_o  output  ADDR_WIDTH  base address the writer shall use.
REQ-012 rd_frame_addr_o  output  ADDR_WIDTH  base address the reader shall use.
REQ-013 rd_frame_valid_o  output  1  reader owns a completed frame.
REQ-014 drop_stb_o / repeat_stb_o  output  1 each  1-cycle event pulses.
REQ-015 drop_cnt_o / repeat_cnt_o  output  CNT_WIDTH each  saturating event counters.

Function
REQ-016 State: wr_idx, rd_idx, rdy_idx (index width $clog2(FRAMES_AMOUNT)), rdy_valid, rd_active; all outputs registered.
REQ-017 Slot roles: wr_idx = writing, rd_idx = reading (if rd_active), rdy_idx = newest complete unread (if rdy_valid); the three never coincide while valid.
REQ-018 On wr_done_stb_i: rdy_idx <= wr_idx, rdy_valid <= 1; if rdy_valid was already 1 and that slot is not taken by the reader this cycle, drop_stb_o = 1 next cycle, drop_cnt_o += 1.
REQ-019 Writer next slot: first k in wr_idx+1, wr_idx+2, ... (mod FRAMES_AMOUNT) with k != post-update rd_idx (check only when post-update rd_active = 1).
REQ-020 Reader advance event = rd_done_stb_i, or (rd_active = 0 and post-writer-update rdy_valid = 1).
REQ-021 On advance with freeze_i = 0 and a ready frame (including one completed the same cycle): rd_idx <= that ready slot, rdy_valid <= 0, rd_active <= 1; old reading slot becomes free.
REQ-022 On rd_done_stb_i with no ready frame or freeze_i = 1: rd_idx unchanged, repeat_stb_o = 1 next cycle, repeat_cnt_o += 1; ready frame stays ready.
REQ-023 Simultaneous wr_done_stb_i and rd_done_stb_i: writer update evaluated first; reader takes the frame just completed; no drop counted for it.
REQ-024 Index wrap: FRAMES_AMOUNT-1 + 1 -> 0.
REQ-025 Addresses: *_frame_addr_o = START_ADDR + idx * BYTES_PER_FRAME, truncated to ADDR_WIDTH, updated the cycle after the strobe (latency 1).
REQ-026 rd_frame_valid_o = rd_active; rd_frame_addr_o is meaningful only when high.
REQ-027 Counters saturate at all-ones; no wrap.
REQ-028 Strobes arriving during rst_i are ignored.

Reset
REQ-029 On rst_i: wr_idx = 0, rd_idx = 0, rdy_idx = 0, rdy_valid = 0, rd_active = 0.
REQ-030 On rst_i: wr_frame_addr_o = rd_frame_addr_o = START_ADDR, rd_frame_valid_o = 0, strobes = 0, counters = 0.
REQ-031 Reset mid-operation discards all slot state; first frame after reset restarts at slot 0.

Verification
REQ-032 Startup: reset, single wr_done -> wr_frame_addr_o = 4147200 next cycle; one cycle later rd_frame_valid_o = 1, rd_frame_addr_o = 0.
REQ-033 Writer fast: reader on slot 0, two wr_done pulses, no rd_done -> writer 1 -> 2 -> 1 (skips 0); one drop_stb_o; drop_cnt_o = 1.
REQ-034 Reader fast: rd_done with rdy_valid = 0 -> repeat_stb_o = 1; rd_frame_addr_o unchanged; repeat_cnt_o = 1.
REQ-035 Simultaneous: reader slot 0, writer slot 1, rdy_valid = 0, both strobes same cycle -> rd_idx = 1, wr_idx = 2, no drop, no repeat.
REQ-036 Freeze: freeze_i = 1, ready frame present, rd_done -> repeat counted, rd_idx held; release and next rd_done -> reader moves to the ready slot.
REQ-037 Saturation/reset: CNT_WIDTH = 2, force 5 repeats -> repeat_cnt_o = 3; assert rst_i mid-stream -> all outputs at REQ-029/030 values the next cycle.
